// File: rtl/fib_lcd_sequencer.sv
// ============================================================================
// fib_lcd_sequencer
//   Turns button edges into Fibonacci requests and ships results to the LCD.
//   Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module fib_lcd_sequencer #(
   parameter int               WIDTH    = 16,
   parameter int               N_MAX    = 24,
   parameter int               TIMEOUT  = 1024,
   parameter logic [WIDTH-1:0] ERR_CODE = 'hDEAD
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             set_a,
   input  logic             set_b,
   input  logic [3:0]       switches,
   output logic             fib_start,
   output logic [4:0]       fib_n,
   input  logic             fib_done,
   input  logic [WIDTH-1:0] fib_result,
   output logic             disp_valid,
   output logic [WIDTH-1:0] disp_data,
   input  logic             disp_ready,
   output logic             busy,
   output logic [4:0]       cur_index,
   output logic             ovf,
   output logic             timeout_err
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_SEND  = 2'd3;

   localparam int               CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [4:0]       N_MAX_IDX = 5'(N_MAX);

   logic [1:0]       state_q, state_d;
   logic [4:0]       index_q, index_d;
   logic             pending_q, pending_d;
   logic [4:0]       fib_n_q, fib_n_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             ovf_q, ovf_d;
   logic             tmo_q, tmo_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             set_a_q, set_b_q;
   logic             ev_a, ev_b;

   assign ev_a = set_a & ~set_a_q;
   assign ev_b = set_b & ~set_b_q;

   always_comb begin
      state_d   = state_q;
      index_d   = index_q;
      pending_d = pending_q;
      fib_n_d   = fib_n_q;
      data_d    = data_q;
      ovf_d     = ovf_q;
      tmo_d     = tmo_q;
      cnt_d     = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (pending_q) begin
               pending_d = 1'b0;
               ovf_d     = 1'b0;
               tmo_d     = 1'b0;
               // Out-of-range indices skip the engine and display all ones.
               if (index_q > N_MAX_IDX) begin
                  ovf_d   = 1'b1;
                  data_d  = '1;
                  state_d = S_SEND;
               end else begin
                  fib_n_d = index_q;
                  state_d = S_START;
               end
            end
         end
         S_START: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (fib_done) begin
               data_d  = fib_result;
               state_d = S_SEND;
            end else if (cnt_q == CNT_LAST) begin
               data_d  = ERR_CODE;
               tmo_d   = 1'b1;
               state_d = S_SEND;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_SEND: begin
            if (disp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Button events apply in every state; a new event overrides the IDLE clear.
      if (ev_a) begin
         index_d = {1'b0, switches};
      end else if (ev_b) begin
         index_d = index_q + 5'd1;
      end
      if (ev_a | ev_b) pending_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         index_q   <= '0;
         pending_q <= 1'b1;
         fib_n_q   <= '0;
         data_q    <= '0;
         ovf_q     <= 1'b0;
         tmo_q     <= 1'b0;
         cnt_q     <= '0;
         set_a_q   <= 1'b0;
         set_b_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         index_q   <= index_d;
         pending_q <= pending_d;
         fib_n_q   <= fib_n_d;
         data_q    <= data_d;
         ovf_q     <= ovf_d;
         tmo_q     <= tmo_d;
         cnt_q     <= cnt_d;
         set_a_q   <= set_a;
         set_b_q   <= set_b;
      end
   end

   assign fib_start   = (state_q == S_START);
   assign disp_valid  = (state_q == S_SEND);
   assign busy        = (state_q != S_IDLE);
   assign fib_n       = fib_n_q;
   assign disp_data   = data_q;
   assign cur_index   = index_q;
   assign ovf         = ovf_q;
   assign timeout_err = tmo_q;

endmodule

`default_nettype wire

// File: tb/tb_fib_lcd_sequencer.sv
// ============================================================================
// tb_fib_lcd_sequencer
//   Directed + random stimulus against a cycle-level behavioural model.
//   Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fib_lcd_sequencer;

   localparam int WIDTH   = 16;
   localparam int N_MAX   = 24;
   localparam int TIMEOUT = 1024;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             set_a = 1'b0;
   logic             set_b = 1'b0;
   logic [3:0]       switches = 4'd0;
   logic             fib_done = 1'b0;
   logic [WIDTH-1:0] fib_result = '0;
   logic             disp_ready = 1'b0;
   logic             fib_start;
   logic [4:0]       fib_n;
   logic             disp_valid;
   logic [WIDTH-1:0] disp_data;
   logic             busy;
   logic [4:0]       cur_index;
   logic             ovf;
   logic             timeout_err;

   fib_lcd_sequencer #(
      .WIDTH   (WIDTH),
      .N_MAX   (N_MAX),
      .TIMEOUT (TIMEOUT),
      .ERR_CODE(16'hDEAD)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .set_a      (set_a),
      .set_b      (set_b),
      .switches   (switches),
      .fib_start  (fib_start),
      .fib_n      (fib_n),
      .fib_done   (fib_done),
      .fib_result (fib_result),
      .disp_valid (disp_valid),
      .disp_data  (disp_data),
      .disp_ready (disp_ready),
      .busy       (busy),
      .cur_index  (cur_index),
      .ovf        (ovf),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] fib_value(input int n);
      int a, b, t;
      a = 0;
      b = 1;
      for (int i = 0; i < n; i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return 16'(a);
   endfunction

   // Behavioural model: what the display/engine side should see each cycle
   typedef enum int {M_IDLE, M_START, M_WAIT, M_SHOW} mphase_t;
   mphase_t     m_phase = M_IDLE;
   int          m_idx   = 0;
   bit          m_pend  = 1'b1;
   int          m_fn    = 0;
   logic [15:0] m_data  = 16'h0;
   bit          m_ovf   = 1'b0;
   bit          m_tmo   = 1'b0;
   bit          m_pa    = 1'b0;
   bit          m_pb    = 1'b0;
   longint      cyc     = 0;
   longint      t_start = 0;
   bit          started = 1'b0;

   always @(posedge clk) begin
      longint cur;
      bit ea, eb;
      cur = cyc;
      cyc++;
      started = 1'b1;
      if (reset) begin
         m_phase = M_IDLE; m_idx = 0; m_pend = 1'b1; m_fn = 0;
         m_data = 16'h0; m_ovf = 1'b0; m_tmo = 1'b0; m_pa = 1'b0; m_pb = 1'b0;
      end else begin
         ea = set_a && !m_pa;
         eb = set_b && !m_pb;
         case (m_phase)
            M_IDLE: if (m_pend) begin
               m_pend = 1'b0; m_ovf = 1'b0; m_tmo = 1'b0;
               if (m_idx > N_MAX) begin
                  m_ovf = 1'b1; m_data = 16'hFFFF; m_phase = M_SHOW;
               end else begin
                  m_fn = m_idx; m_phase = M_START;
               end
            end
            M_START: begin
               t_start = cur;
               m_phase = M_WAIT;
            end
            M_WAIT: begin
               if (fib_done) begin
                  m_data = fib_value(m_fn); m_phase = M_SHOW;
               end else if (cur - t_start == TIMEOUT) begin
                  m_data = 16'hDEAD; m_tmo = 1'b1; m_phase = M_SHOW;
               end
            end
            M_SHOW: if (disp_ready) m_phase = M_IDLE;
            default: m_phase = M_IDLE;
         endcase
         if (ea) m_idx = int'(switches);
         else if (eb) m_idx = (m_idx + 1) % 32;
         if (ea || eb) m_pend = 1'b1;
         m_pa = set_a;
         m_pb = set_b;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("busy",        32'(busy),        32'(m_phase != M_IDLE));
         chk("fib_start",   32'(fib_start),   32'(m_phase == M_START));
         chk("disp_valid",  32'(disp_valid),  32'(m_phase == M_SHOW));
         chk("fib_n",       32'(fib_n),       32'(m_fn));
         chk("disp_data",   32'(disp_data),   32'(m_data));
         chk("cur_index",   32'(cur_index),   32'(m_idx));
         chk("ovf",         32'(ovf),         32'(m_ovf));
         chk("timeout_err", 32'(timeout_err), 32'(m_tmo));
      end
   end

   // Engine stand-in: eng_delay <0 random 1..8, 0 never answers, >0 fixed delay
   int eng_delay = 3;
   int eng_cnt   = 0;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         fib_done   = 1'b0;
         fib_result = 16'($urandom);
         if (reset) begin
            eng_cnt = 0;
         end else if (fib_start) begin
            eng_cnt = (eng_delay < 0) ? int'($urandom_range(1, 8)) : eng_delay;
         end else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
               fib_done   = 1'b1;
               fib_result = fib_value(int'(fib_n));
            end
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_a(input logic [3:0] sw);
      switches = sw;
      set_a = 1'b1;
      step();
      set_a = 1'b0;
      step();
   endtask

   task automatic pulse_b();
      set_b = 1'b1;
      step();
      set_b = 1'b0;
      step();
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      while (!(m_phase == M_IDLE && !m_pend) && k < budget) begin
         step();
         k++;
      end
      chk("wait_idle", 32'(m_phase == M_IDLE && !m_pend), 32'd1);
   endtask

   task automatic wait_show(input int budget);
      int k;
      k = 0;
      while (m_phase != M_SHOW && k < budget) begin
         step();
         k++;
      end
      chk("wait_show", 32'(m_phase == M_SHOW), 32'd1);
   endtask

   initial begin
      reset = 1'b1;
      disp_ready = 1'b1;
      eng_delay = 3;
      step(3);
      reset = 1'b0;
      wait_idle(40);

      pulse_a(4'hA);
      wait_idle(40);
      pulse_b();
      wait_idle(40);

      // Walk up to 24 with events collapsing while busy, then step into overflow
      pulse_a(4'hF);
      repeat (9) pulse_b();
      wait_idle(80);
      pulse_b();
      wait_idle(40);
      pulse_a(4'h3);
      wait_idle(40);

      // Hung engine whose done arrives only after the timeout
      eng_delay = TIMEOUT + 3;
      pulse_b();
      wait_idle(TIMEOUT + 40);
      step(10);

      // Back-pressure from the display with events arriving during SEND
      eng_delay = 3;
      disp_ready = 1'b0;
      pulse_a(4'h4);
      wait_show(40);
      pulse_a(4'h5);
      pulse_b();
      step(2);
      disp_ready = 1'b1;
      wait_idle(40);

      switches = 4'h7;
      set_a = 1'b1;
      set_b = 1'b1;
      step();
      set_a = 1'b0;
      set_b = 1'b0;
      step();
      wait_idle(40);

      // Reset in the middle of WAIT
      eng_delay = 0;
      pulse_b();
      step(4);
      reset = 1'b1;
      step();
      reset = 1'b0;
      eng_delay = 2;
      wait_idle(40);

      eng_delay = -1;
      for (int i = 0; i < 600; i++) begin
         set_a      = ($urandom_range(0, 19) == 0);
         set_b      = ($urandom_range(0, 9) == 0);
         switches   = 4'($urandom);
         disp_ready = ($urandom_range(0, 2) != 0);
         step();
      end
      set_a = 1'b0;
      set_b = 1'b0;
      disp_ready = 1'b1;
      wait_idle(100);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fib_lcd_sequencer.md
Name: fib_lcd_sequencer

Overview:
Control block between the board inputs, the Fibonacci compute engine and the character-LCD controller. It turns SetA/SetB button edges into an index update and issues a start to the Fibonacci engine. It waits for the engine's done, then hands the 16-bit result to the LCD controller over a valid/ready handshake. It also handles index overflow, engine timeout and button events that arrive while a transaction is in flight.

Parameters:
WIDTH, 16, result/display data width
N_MAX, 24, largest index whose F(n) fits in WIDTH bits (F(24)=46368)
TIMEOUT, 1024, cycles allowed in WAIT before the engine is declared hung
ERR_CODE, 16'hDEAD, display value sent on timeout

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
set_a  in  1  button A, already synchronised/debounced; load index from switches
set_b  in  1  button B, already synchronised/debounced; increment index
switches  in  4  index value loaded on set_a
fib_start  out  1  one-cycle start pulse to the Fibonacci engine
fib_n  out  5  index presented to the engine; stable from START until done
fib_done  in  1  engine completion strobe, single cycle
fib_result  in  WIDTH  engine result, valid when fib_done=1
disp_valid  out  1  display data valid
disp_data  out  WIDTH  value to display
disp_ready  in  1  LCD controller accepts disp_data
busy  out  1  high in any state other than IDLE
cur_index  out  5  current index register, for LEDs
ovf  out  1  last request had index > N_MAX (sticky until next request)
timeout_err  out  1  last request timed out (sticky until next request)

Behaviour:
- Reset (sync, active-high) gives: state=IDLE, index=0, pending=1, fib_start=0, fib_n=0, disp_valid=0, disp_data=0, ovf=0, timeout_err=0, busy=0. The pending flag means F(0) is always displayed after reset.
- Reset asserted in any state aborts the current transaction on the next edge. fib_done or disp_ready seen during reset is ignored.
- Edge detect: a button event is set_x=1 where the registered previous value was 0. The edge registers clear to 0 on reset.
- Event handling, evaluated every cycle in every state:
  - set_a event: index <= {1'b0, switches}.
  - set_b event: index <= index+1, wrapping 31->0.
  - Both in the same cycle: set_a wins and set_b is dropped.
  - Any event sets pending=1. Multiple events while busy collapse into one pending request that uses the latest index.
- IDLE: if pending, clear pending, clear ovf and timeout_err, then:
  - index > N_MAX: set ovf=1, disp_data <= {WIDTH{1}}, go to SEND. No engine start.
  - otherwise: fib_n <= index, go to START.
- START: fib_start=1 for exactly one cycle; clear the timeout counter; go to WAIT.
- WAIT: the counter increments each cycle.
  - fib_done=1: disp_data <= fib_result, go to SEND. fib_done wins over timeout in the same cycle.
  - counter reaches TIMEOUT-1 without done: disp_data <= ERR_CODE, timeout_err=1, go to SEND.
  - A late fib_done arriving after the block has left WAIT is ignored.
- SEND: disp_valid=1 with disp_data held stable. On disp_valid & disp_ready, transfer completes, disp_valid drops next cycle, go to IDLE.
- Latency: IDLE with pending -> fib_start is 1 cycle; fib_done -> disp_valid is 1 cycle; accepted -> next fib_start is 2 cycles (IDLE, START).
- busy = (state != IDLE). fib_n holds its value outside START/WAIT. cur_index always reflects the index register.
- Index register is 5 bits, so 16..31 are reachable only via set_b. Indices 25..31 always take the overflow path.

Test Plan:
- Reset release; engine model returns 0 three cycles after start -> one fib_start pulse with fib_n=0; disp_valid with disp_data=0x0000; disp_ready=1 -> busy drops 1 cycle later.
- switches=4'hA, set_a edge -> fib_n=10; model returns 55 -> disp_data=0x0037. Then set_b edge -> fib_n=11, disp_data=0x0059.
- From index=24, set_b -> cur_index=25, ovf=1, no fib_start, disp_data=0xFFFF. Next set_a with switches=3 -> ovf clears, disp_data=0x0002.
- Engine model never asserts done -> exactly TIMEOUT cycles after fib_start, disp_data=0xDEAD and timeout_err=1. A later fib_done is ignored (no second disp_valid).
- disp_ready held low 6 cycles in SEND, with set_a (switches=5) then set_b pulsed -> disp_data stable throughout. After acceptance, a single new request runs with fib_n=6 and disp_data=0x0008. Same-cycle set_a/set_b -> only the set_a index is loaded.
- Reset asserted mid-WAIT -> next edge: fib_start=0, disp_valid=0, cur_index=0. After release, F(0) is recomputed and displayed.
